// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: request/address out of the fetch unit,
// acknowledge back from the memory.
interface pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter / instruction-fetch sequencer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | first cycle out of reset, no request, redirects ignored
// REQ   | imem_req high, waiting for imem_ack at the current pc
// HOLD  | instruction accepted but downstream stalled, pc parked
//
// A redirect (jump wins over branch_taken) in REQ or HOLD always loads the
// word-aligned target and returns to REQ, even under stall. An ack that
// lands in the same cycle as a redirect belongs to the old path and is
// dropped.
module pc_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    pc_fetch_if.master       imem,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] fetch_count_q, fetch_count_d;

    logic             redirect;
    logic [WIDTH-1:0] redirect_raw;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] pc_inc;

    // Sequential pc increment and redirect target selection (jump has priority).
    always_comb begin
        pc_inc       = pc_q + WIDTH'(4);
        redirect     = jump | branch_taken;
        redirect_raw = jump ? jump_target : branch_target;
        redirect_pc  = {redirect_raw[WIDTH-1:2], 2'b00};
    end

    // State, pc and fetch-report registers; reset aborts any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state, next-pc and acceptance logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (imem.imem_ack) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    fetch_count_d = fetch_count_q + WIDTH'(1);
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_inc;
    assign fetch_valid    = fetch_valid_q;
    assign fetch_pc       = fetch_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a behavioural reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;

    pc_fetch_if #(.WIDTH(32)) imem_if ();

    pc_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (imem_if),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "started" means the first post-reset cycle is over,
    // "parked" means an accepted instruction is waiting for stall to clear.
    logic [31:0] m_pc, m_fpc, m_cnt, m_tgt;
    bit          m_started, m_parked, m_fv, m_redir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      = 32'h0;
            m_fpc     = 32'h0;
            m_cnt     = 32'h0;
            m_started = 1'b0;
            m_parked  = 1'b0;
            m_fv      = 1'b0;
        end else begin
            m_fv    = 1'b0;
            m_redir = jump || branch_taken;
            m_tgt   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_redir) begin
                m_pc     = m_tgt;
                m_parked = 1'b0;
            end else if (m_parked) begin
                if (!stall) begin
                    m_pc     = m_pc + 32'd4;
                    m_parked = 1'b0;
                end
            end else if (imem_if.imem_ack) begin
                m_fv  = 1'b1;
                m_fpc = m_pc;
                m_cnt = m_cnt + 32'd1;
                if (stall) m_parked = 1'b1;
                else       m_pc     = m_pc + 32'd4;
            end
        end
    end

    bit cmp_en = 1'b0;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_imem_req",    {31'b0, imem_if.imem_req}, {31'b0, (m_started && !m_parked)});
            chk("m_imem_addr",   imem_if.imem_addr, m_pc);
            chk("m_pc",          pc, m_pc);
            chk("m_pc_plus4",    pc_plus4, m_pc + 32'd4);
            chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
            chk("m_fetch_pc",    fetch_pc, m_fpc);
            chk("m_fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look(input string tag, input logic [31:0] e_pc, input logic e_req,
                        input logic e_fv, input logic [31:0] e_fpc, input logic [31:0] e_cnt);
        chk({tag, "_pc"},   pc, e_pc);
        chk({tag, "_req"},  {31'b0, imem_if.imem_req}, {31'b0, e_req});
        chk({tag, "_fv"},   {31'b0, fetch_valid}, {31'b0, e_fv});
        chk({tag, "_fpc"},  fetch_pc, e_fpc);
        chk({tag, "_cnt"},  fetch_count, e_cnt);
    endtask

    initial begin
        rst_n            = 1'b0;
        stall            = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = 32'h0;
        jump             = 1'b0;
        jump_target      = 32'h0;
        imem_if.imem_ack = 1'b1;

        // Reset held with ack high: nothing may be accepted.
        step();
        cmp_en = 1'b1;
        step();
        look("rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Streaming fetch with ack held high.
        rst_n = 1'b1;
        step(); look("seq1", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0);
        step(); look("seq2", 32'h4, 1'b1, 1'b1, 32'h0, 32'd1);
        step(); look("seq3", 32'h8, 1'b1, 1'b1, 32'h4, 32'd2);
        step(); look("seq4", 32'hC, 1'b1, 1'b1, 32'h8, 32'd3);

        // Accept at 12 under stall, stay parked for three cycles.
        stall = 1'b1;
        step(); look("stl1", 32'hC, 1'b0, 1'b1, 32'hC, 32'd4);
        step(); look("stl2", 32'hC, 1'b0, 1'b0, 32'hC, 32'd4);
        step(); look("stl3", 32'hC, 1'b0, 1'b0, 32'hC, 32'd4);
        stall = 1'b0;
        imem_if.imem_ack = 1'b0;
        step(); look("unstl", 32'h10, 1'b1, 1'b0, 32'hC, 32'd4);
        step(); look("noack", 32'h10, 1'b1, 1'b0, 32'hC, 32'd4);

        // Jump to 4 with a colliding ack, then branch from 4 to 8 with an ack.
        imem_if.imem_ack = 1'b1;
        jump = 1'b1; jump_target = 32'h4;
        step(); look("jmp4", 32'h4, 1'b1, 1'b0, 32'hC, 32'd4);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h8;
        step(); look("br8", 32'h8, 1'b1, 1'b0, 32'hC, 32'd4);

        // Jump wins over branch and its target is word-aligned.
        branch_target = 32'h40; jump = 1'b1; jump_target = 32'h83;
        step(); chk("prio_pc", pc, 32'h80);
        branch_taken = 1'b0;

        // Wrap at the top of the address space.
        jump_target = 32'hFFFF_FFFF;
        step(); chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_plus4", pc_plus4, 32'h0);
        jump = 1'b0;
        step(); look("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd5);

        // Redirect from HOLD overrides stall.
        stall = 1'b1;
        step(); look("hold", 32'h0, 1'b0, 1'b1, 32'h0, 32'd6);
        branch_taken = 1'b1; branch_target = 32'h20;
        step(); look("holdbr", 32'h20, 1'b1, 1'b0, 32'h0, 32'd6);
        branch_taken = 1'b0; stall = 1'b0;
        step(); look("postbr", 32'h24, 1'b1, 1'b1, 32'h20, 32'd7);

        // Asynchronous reset between edges, ack kept high throughout.
        #1 rst_n = 1'b0;
        #1 look("arst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step(); look("arst2", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Restart; a jump present on the IDLE cycle is ignored.
        jump = 1'b1; jump_target = 32'h100;
        rst_n = 1'b1;
        step(); look("re1", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0);
        jump = 1'b0;
        step(); look("re2", 32'h4, 1'b1, 1'b1, 32'h0, 32'd1);
        step(); look("re3", 32'h8, 1'b1, 1'b1, 32'h4, 32'd2);

        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
